// File: rtl/life_gen_ctrl.sv
// Game of Life generation sequencer: reads every row into a local buffer, then writes back the next generation.
// One generation = 10 busy cycles; requests arriving while busy are dropped, and the auto-run tick is held until IDLE.
module life_gen_ctrl #(
    parameter int ROWS   = 4,
    parameter int COLS   = 16,
    parameter int ADDR_W = 2,
    parameter int PERIOD = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_req,
    input  logic              run_en,
    input  logic              load_req,
    output logic              mem_debug,
    output logic              mem_write_enb,
    output logic [ADDR_W-1:0] mem_array_selector,
    output logic [COLS-1:0]   mem_alive_in,
    input  logic [COLS-1:0]   mem_alive_out,
    output logic              busy,
    output logic              done,
    output logic [15:0]       gen_count
);
    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_READ, S_CAPTURE, S_WRITE, S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_row, w_row_nxt;
    logic [COLS-1:0]   r_buf [ROWS];
    logic [COLS-1:0]   w_eff [ROWS];
    logic [COLS-1:0]   w_up, w_mid, w_dn, w_life;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_tick_pending;
    logic              w_start;

    logic              r_debug, r_we, r_busy, r_done;
    logic [ADDR_W-1:0] r_sel;
    logic [COLS-1:0]   r_din;
    logic [15:0]       r_gen_count;
    logic              w_debug_nxt, w_we_nxt, w_busy_nxt, w_done_nxt;
    logic [ADDR_W-1:0] w_sel_nxt;
    logic [COLS-1:0]   w_din_nxt;

    function automatic logic [COLS-1:0] f_life(input logic [COLS-1:0] up,
                                               input logic [COLS-1:0] mid,
                                               input logic [COLS-1:0] dn);
        logic [3:0] n;
        f_life = '0;
        for (int c = 0; c < COLS; c++) begin
            n = 4'(up[(c + COLS - 1) % COLS]) + 4'(up[c]) + 4'(up[(c + 1) % COLS])
              + 4'(mid[(c + COLS - 1) % COLS]) + 4'(mid[(c + 1) % COLS])
              + 4'(dn[(c + COLS - 1) % COLS]) + 4'(dn[c]) + 4'(dn[(c + 1) % COLS]);
            f_life[c] = (n == 4'd3) || (mid[c] && (n == 4'd2));
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (load_req)
                    w_state_nxt = S_LOAD;
                else if (step_req || r_tick_pending)
                    w_state_nxt = S_READ;
            end
            S_LOAD:    w_state_nxt = S_IDLE;
            S_READ: begin
                if (r_row == LAST_ROW) begin
                    w_state_nxt = S_CAPTURE;
                    w_row_nxt   = r_row;
                end else begin
                    w_row_nxt   = r_row + 1'b1;
                end
            end
            S_CAPTURE: w_state_nxt = S_WRITE;
            S_WRITE: begin
                if (r_row == LAST_ROW)
                    w_state_nxt = S_DONE;
                else
                    w_row_nxt   = r_row + 1'b1;
            end
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    assign w_start = (r_state == S_IDLE) && (w_state_nxt == S_READ);

    // The last row lands in the buffer on the same edge that registers the first write row, so bypass it in.
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            w_eff[r] = r_buf[r];
        if (r_state == S_CAPTURE)
            w_eff[ROWS-1] = mem_alive_out;
    end

    always_comb begin
        w_up   = w_eff[(w_row_nxt == '0) ? LAST_ROW : w_row_nxt - 1'b1];
        w_mid  = w_eff[w_row_nxt];
        w_dn   = w_eff[(w_row_nxt == LAST_ROW) ? '0 : w_row_nxt + 1'b1];
        w_life = f_life(w_up, w_mid, w_dn);
    end

    always_comb begin
        w_debug_nxt = (w_state_nxt == S_LOAD);
        w_we_nxt    = (w_state_nxt == S_WRITE);
        w_busy_nxt  = (w_state_nxt inside {S_READ, S_CAPTURE, S_WRITE, S_DONE});
        w_done_nxt  = (w_state_nxt == S_DONE);
        w_sel_nxt   = (w_state_nxt inside {S_READ, S_CAPTURE, S_WRITE}) ? w_row_nxt : '0;
        w_din_nxt   = w_we_nxt ? w_life : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_debug     <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sel       <= '0;
            r_din       <= '0;
            r_gen_count <= '0;
        end else begin
            r_debug <= w_debug_nxt;
            r_we    <= w_we_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_sel   <= w_sel_nxt;
            r_din   <= w_din_nxt;
            if (w_done_nxt)
                r_gen_count <= r_gen_count + 16'd1;
        end
    end

    // Read data trails the address by one cycle, so READ row k captures row k-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++)
                r_buf[r] <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_buf[ROWS-1] <= mem_alive_out;
        end else if ((r_state == S_READ) && (r_row != '0)) begin
            r_buf[r_row - 1'b1] <= mem_alive_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !run_en) begin
            r_cnt          <= '0;
            r_tick_pending <= 1'b0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt          <= '0;
            r_tick_pending <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_start)
                r_tick_pending <= 1'b0;
        end
    end

    assign mem_debug          = r_debug;
    assign mem_write_enb      = r_we;
    assign mem_array_selector = r_sel;
    assign mem_alive_in       = r_din;
    assign busy               = r_busy;
    assign done               = r_done;
    assign gen_count          = r_gen_count;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Bench for life_gen_ctrl: row-memory model plus a toroidal Life reference applied to directed and random patterns.
module tb_life_gen_ctrl;
    logic        clk;
    logic        reset;
    logic        step_req;
    logic        run_en;
    logic        load_req;
    logic        mem_debug;
    logic        mem_write_enb;
    logic [1:0]  mem_array_selector;
    logic [15:0] mem_alive_in;
    logic [15:0] mem_alive_out;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_gc = 0;

    logic [15:0] mem [4];
    logic        tb_ld;
    logic [1:0]  tb_ld_row;
    logic [15:0] tb_ld_dat;

    life_gen_ctrl #(.ROWS(4), .COLS(16), .ADDR_W(2), .PERIOD(20)) dut (
        .clk                (clk),
        .reset              (reset),
        .step_req           (step_req),
        .run_en             (run_en),
        .load_req           (load_req),
        .mem_debug          (mem_debug),
        .mem_write_enb      (mem_write_enb),
        .mem_array_selector (mem_array_selector),
        .mem_alive_in       (mem_alive_in),
        .mem_alive_out      (mem_alive_out),
        .busy               (busy),
        .done               (done),
        .gen_count          (gen_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Row memory with a one-cycle registered read, plus a bench-side preload path.
    always @(posedge clk) begin
        if (tb_ld)
            mem[tb_ld_row] <= tb_ld_dat;
        else if (mem_write_enb)
            mem[mem_array_selector] <= mem_alive_in;
        mem_alive_out <= mem[mem_array_selector];
    end

    function automatic logic [63:0] life_ref(input logic [63:0] g);
        logic [63:0] o;
        int n;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(g[((r + dr + 4) % 4) * 16 + ((c + dc + 16) % 16)]);
                o[r*16 + c] = (n == 3) || (g[r*16 + c] && n == 2);
            end
        end
        return o;
    endfunction

    function automatic logic [63:0] grid();
        return {mem[3], mem[2], mem[1], mem[0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_rows(input logic [15:0] r0, input logic [15:0] r1,
                             input logic [15:0] r2, input logic [15:0] r3);
        logic [15:0] v [4];
        v = '{r0, r1, r2, r3};
        for (int i = 0; i < 4; i++) begin
            tb_ld     = 1'b1;
            tb_ld_row = 2'(i);
            tb_ld_dat = v[i];
            @(negedge clk);
        end
        tb_ld = 1'b0;
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge of cycle N+11.
    task automatic do_step(input bit poke);
        logic [63:0] nx;
        int es;
        nx = life_ref(grid());
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            if (j > 1) @(negedge clk);
            if (poke) begin
                step_req = (j >= 3 && j <= 5);
                load_req = (j == 4);
            end
            check($sformatf("busy j=%0d", j), 64'(busy), 64'(j <= 10));
            check($sformatf("done j=%0d", j), 64'(done), 64'(j == 10));
            check($sformatf("debug j=%0d", j), 64'(mem_debug), 64'd0);
            check($sformatf("we j=%0d", j), 64'(mem_write_enb), 64'(j >= 6 && j <= 9));
            check($sformatf("gen j=%0d", j), 64'(gen_count), 64'((j >= 10) ? exp_gc + 1 : exp_gc) & 64'hFFFF);
            if (j <= 9) begin
                es = (j <= 4) ? j - 1 : (j == 5) ? 3 : j - 6;
                check($sformatf("sel j=%0d", j), 64'(mem_array_selector), 64'(es));
            end
            if (j >= 6 && j <= 9)
                check($sformatf("wdata row%0d", j - 6), 64'(mem_alive_in), 64'(nx[(j-6)*16 +: 16]));
        end
        exp_gc++;
        check("mem after gen", grid(), nx);
    endtask

    initial begin
        int dn_cnt;
        int prev_busy;
        int cyc;
        int starts [$];

        reset = 1'b1; step_req = 1'b0; run_en = 1'b0; load_req = 1'b0;
        tb_ld = 1'b0; tb_ld_row = '0; tb_ld_dat = '0;
        repeat (2) @(negedge clk);
        check("rst we", 64'(mem_write_enb), 64'd0);
        check("rst debug", 64'(mem_debug), 64'd0);
        check("rst sel", 64'(mem_array_selector), 64'd0);
        check("rst din", 64'(mem_alive_in), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst gen", 64'(gen_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Blinker oscillates with period 2
        load_rows(16'h0000, 16'h0070, 16'h0000, 16'h0000);
        do_step(1'b0);
        check("blinker gen1", grid(), {16'h0000, 16'h0020, 16'h0020, 16'h0020});
        do_step(1'b0);
        check("blinker gen2", grid(), {16'h0000, 16'h0000, 16'h0070, 16'h0000});
        check("blinker count", 64'(gen_count), 64'd2);

        // 2x2 block straddling the column seam is a still life
        load_rows(16'h8001, 16'h8001, 16'h0000, 16'h0000);
        do_step(1'b0);
        check("still life", grid(), {16'h0000, 16'h0000, 16'h8001, 16'h8001});

        // load_req wins over step_req in IDLE
        load_req = 1'b1; step_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0; step_req = 1'b0;
        check("load debug hi", 64'(mem_debug), 64'd1);
        check("load busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("load debug lo", 64'(mem_debug), 64'd0);
        dn_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || mem_debug) dn_cnt++;
        end
        check("load no gen", 64'(dn_cnt), 64'd0);
        check("load gen hold", 64'(gen_count), 64'd3);

        // Requests during busy are dropped
        load_rows(16'h0000, 16'h0070, 16'h0000, 16'h0000);
        do_step(1'b1);
        dn_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy) dn_cnt++;
        end
        check("busy step ignored", 64'(dn_cnt), 64'd0);
        check("busy gen count", 64'(gen_count), 64'd4);

        // Reset in the middle of WRITE
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (6) @(negedge clk);
        check("midwr we", 64'(mem_write_enb), 64'd1);
        check("midwr sel", 64'(mem_array_selector), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst we", 64'(mem_write_enb), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst gen", 64'(gen_count), 64'd0);
        check("midrst sel", 64'(mem_array_selector), 64'd0);
        dn_cnt = 0;
        repeat (15) begin
            if (done || busy) dn_cnt++;
            @(negedge clk);
        end
        check("midrst no done", 64'(dn_cnt), 64'd0);
        exp_gc = 0;

        // Auto-run: one start per PERIOD while run_en is high
        prev_busy = 0;
        cyc = 0;
        run_en = 1'b1;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            cyc++;
            if (i == 99) run_en = 1'b0;
            if (busy && prev_busy == 0) starts.push_back(cyc);
            prev_busy = int'(busy);
        end
        check("autorun starts", 64'(starts.size()), 64'(100 / 20));
        for (int i = 1; i < starts.size(); i++)
            check($sformatf("autorun gap%0d", i), 64'(starts[i] - starts[i-1]), 64'd20);
        exp_gc += starts.size();
        check("autorun gen", 64'(gen_count), 64'(exp_gc));

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_gc = 0;
        check("rst2 gen", 64'(gen_count), 64'd0);

        for (int i = 0; i < 200; i++) begin
            if (i % 8 == 0)
                load_rows(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            do_step((i % 5) == 3);
        end
        check("random gen count", 64'(gen_count), 64'd200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/life_gen_ctrl.md
Name: life_gen_ctrl

Overview:
- Sequences one Game of Life generation over the 4-row x 16-column alive-cell row memory through that memory's selector port.
- Each generation is a read-all / compute / write-all pass: every row is buffered before any write-back, so no row is overwritten before its neighbours have used it.
- Triggered by a single-step request or by a free-running period tick. Also owns the memory's debug-pattern load strobe.
- The VGA read port of the memory is untouched by this block.

Parameters:
- ROWS, 4, number of memory rows (indices 0..ROWS-1).
- COLS, 16, cells per row; bit i = column i.
- ADDR_W, 2, row address width, clog2(ROWS).
- PERIOD, 25000000, clk cycles between auto-run generation starts; must be >= 12.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- step_req  in  1  single-step request, sampled in IDLE only.
- run_en  in  1  enables the auto-run period counter.
- load_req  in  1  request the memory debug-pattern load, sampled in IDLE only.
- mem_debug  out  1  debug strobe to the memory.
- mem_write_enb  out  1  write enable to the memory selector port.
- mem_array_selector  out  ADDR_W  row address to the memory selector port.
- mem_alive_in  out  COLS  write data to the memory.
- mem_alive_out  in  COLS  read data from the memory; valid the cycle after the address is presented.
- busy  out  1  high from the first READ cycle through DONE.
- done  out  1  one-cycle pulse at the end of a generation.
- gen_count  out  16  number of completed generations; wraps 16'hFFFF -> 0.

Behaviour:
- Reset values (also forced on any clk edge with reset=1, including mid-generation):
  - state=IDLE.
  - All outputs 0: mem_write_enb, mem_debug, mem_array_selector, mem_alive_in, busy, done, gen_count.
  - Period counter 0, tick_pending 0, row buffer cleared.
- Reset during WRITE leaves the memory partially updated. This is accepted; there is no rollback.
- All outputs are registered.
- States: IDLE, LOAD, READ, CAPTURE, WRITE, DONE.
- IDLE priority, highest first:
  1. load_req -> LOAD.
  2. step_req or tick_pending -> READ with row index r=0; clear tick_pending.
  3. Otherwise stay in IDLE.
- LOAD: mem_debug=1 for exactly one cycle, then IDLE. No busy, done or gen_count change.
- Timing, with step_req sampled at the edge ending cycle N:
  - READ, cycles N+1..N+4: mem_array_selector = 0,1,2,3. Row k is captured into buf[k] at the edge ending cycle N+2+k.
  - CAPTURE, cycle N+5: captures row 3; selector holds 3; no write.
  - WRITE, cycles N+6..N+9: mem_write_enb=1, mem_array_selector=r (0..3), mem_alive_in=next(r).
  - DONE, cycle N+10: done=1, gen_count increments, mem_write_enb=0.
  - IDLE again from cycle N+11.
  - busy=1 for cycles N+1..N+10. Total length is 10 busy cycles.
- next(r), bit c, with toroidal wrap in both axes:
  - Rows r-1 and r+1 are taken mod ROWS; columns c-1 and c+1 are taken mod COLS.
  - n = sum of the 8 neighbour bits from buf (range 0..8, 4-bit sum).
  - Result = (n==3) | (buf[r][c] & n==2).
  - Computed from buf only, never from the memory output.
- Auto-run:
  - With run_en=1 the period counter counts 0..PERIOD-1 and wraps.
  - On wrap it sets tick_pending. tick_pending is held until consumed in IDLE, and at most one tick is pending.
  - run_en=0 clears the counter and tick_pending.
- step_req and load_req while not in IDLE are ignored, not queued.
- step_req and tick_pending together start exactly one generation.
- mem_write_enb is never high outside WRITE. mem_debug is never high outside LOAD.

Test Plan:
- Reset mid-WRITE (assert reset at cycle N+7) -> next cycle: state IDLE, mem_write_enb=0, busy=0, gen_count=0, done never pulses.
- Blinker: rows {0,16'h0070,0,0}, step_req 1 cycle at N -> busy N+1..N+10; writes at N+6..N+9 = {16'h0020,16'h0020,16'h0020,16'h0000}; done at N+10; gen_count=1. A second step restores {0,16'h0070,0,0}, gen_count=2.
- Wrap still-life: rows {16'h8001,16'h8001,0,0}, one step -> rows unchanged, done pulses once.
- load_req and step_req both high in IDLE -> mem_debug high exactly 1 cycle, no generation starts. step_req during busy -> ignored; gen_count advances by 1 only.
- Auto-run with PERIOD=20 and run_en=1 for 100 cycles -> exactly 5 generation starts, each 20 cycles apart. Deassert run_en -> no further starts.
- Random 4x16 patterns: 200 steps against a toroidal golden model -> every written row matches; gen_count=200.
